// File: rtl/dca_lsu_util_pkg.sv
// dca_lsu_util: shared LSU definitions (txn_info layout, FSM states, AXI constants).
package dca_lsu_util;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_OUT} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int BW_ALEN = 8;
  // txn_info = {reuse, last_row, alen[7:0], bitaddr[BW_ADDR+2:0]}
  function automatic int bw_txn_info(input int bw_addr);
    return bw_addr + 3 + BW_ALEN + 2;
  endfunction
  function automatic int ofs_alen(input int bw_addr);
    return bw_addr + 3;
  endfunction
  function automatic int ofs_last(input int bw_addr);
    return bw_addr + 3 + BW_ALEN;
  endfunction
  function automatic int ofs_reuse(input int bw_addr);
    return bw_addr + 3 + BW_ALEN + 1;
  endfunction
  function automatic int axi_size(input int bw_data);
    return $clog2(bw_data / 8);
  endfunction
endpackage

// File: rtl/dca_row_extractor.sv
// dca_row_extractor: right barrel shift of the line buffer by a bit offset, truncated to one row.
module dca_row_extractor #(
  parameter int BW_LINE = 128,
  parameter int BW_ROW  = 32,
  parameter int BW_OFF  = 5
) (
  input  logic [BW_LINE-1:0] i_line,
  input  logic [BW_OFF-1:0]  i_off,
  output logic [BW_ROW-1:0]  o_row
);
  assign o_row = BW_ROW'(i_line >> i_off);
endmodule

// File: rtl/dca_matrix_lsu_rd_engine.sv
// dca_matrix_lsu_rd_engine: one AXI INCR burst per row transaction into a line buffer,
// then a bit-aligned row out on a valid/ready stream; reuse rows re-extract from the buffer.
module dca_matrix_lsu_rd_engine import dca_lsu_util::*; #(
  parameter int BW_ADDR     = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int MAX_BEATS   = 4,
  parameter int BW_ROW      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            txn_valid,
  output logic                            txn_ready,
  input  logic [bw_txn_info(BW_ADDR)-1:0] txn_info,
  output logic [BW_ADDR-1:0]              araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [BW_AXI_DATA-1:0]          rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [BW_ROW-1:0]               row_data,
  output logic                            row_last,
  output logic                            rd_error,
  output logic                            busy
);
  localparam int BW_BA   = BW_ADDR + 3;
  localparam int BW_SZ   = axi_size(BW_AXI_DATA);
  localparam int BW_OFF  = $clog2(BW_AXI_DATA);
  localparam int BW_LINE = MAX_BEATS * BW_AXI_DATA;
  localparam int O_ALEN  = ofs_alen(BW_ADDR);
  localparam int O_LAST  = ofs_last(BW_ADDR);
  localparam int O_REUSE = ofs_reuse(BW_ADDR);
  state_t               r_state, w_state_nxt;
  logic                 r_last, r_err;
  logic [7:0]           r_alen, r_beat;
  logic [BW_BA-1:0]     r_bitaddr;
  logic [BW_LINE-1:0]   r_buf, w_buf_nxt;
  logic [BW_ROW-1:0]    r_row, w_row;
  logic [BW_ADDR-1:0]   w_byte;
  logic [BW_OFF-1:0]    w_off;
  logic                 w_txn_fire, w_beat_fire, w_beat_end, w_beat_err, w_unused;
  assign w_txn_fire  = txn_valid & txn_ready;
  assign w_beat_fire = rvalid & rready;
  assign w_beat_end  = r_beat == r_alen;
  // rlast only cross-checks the count; beats beyond the buffer are dropped and flagged
  assign w_beat_err  = rresp[1] | (rlast != w_beat_end) | (r_beat >= 8'(MAX_BEATS));
  assign w_unused    = rresp[0];
  // a reuse row enters OUT straight from IDLE, before bitaddr is registered
  assign w_off       = (r_state == ST_IDLE) ? txn_info[BW_OFF-1:0] : r_bitaddr[BW_OFF-1:0];
  assign w_byte      = r_bitaddr[BW_BA-1:3];
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (txn_valid) w_state_nxt = txn_info[O_REUSE] ? ST_OUT : ST_ADDR;
      ST_ADDR: if (arready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_beat_fire && w_beat_end) w_state_nxt = ST_OUT;
      default: if (row_ready) w_state_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    w_buf_nxt = r_buf;
    for (int k = 0; k < MAX_BEATS; k++)
      if (w_beat_fire && r_beat == 8'(k)) w_buf_nxt[k*BW_AXI_DATA +: BW_AXI_DATA] = rdata;
  end
  dca_row_extractor #(.BW_LINE(BW_LINE), .BW_ROW(BW_ROW), .BW_OFF(BW_OFF)) u_extract (
    .i_line (w_buf_nxt),
    .i_off  (w_off),
    .o_row  (w_row)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_alen    <= '0;
      r_beat    <= '0;
      r_bitaddr <= '0;
      r_buf     <= '0;
      r_row     <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      if (w_txn_fire) begin
        r_last    <= txn_info[O_LAST];
        r_alen    <= txn_info[O_ALEN +: 8];
        r_bitaddr <= txn_info[BW_BA-1:0];
      end
      if (w_beat_fire) r_beat <= w_beat_end ? '0 : r_beat + 8'd1;
      if (w_beat_fire && w_beat_err) r_err <= 1'b1;
      if (w_state_nxt == ST_OUT && r_state != ST_OUT) r_row <= w_row;
    end
  end
  assign txn_ready = r_state == ST_IDLE;
  assign arvalid   = r_state == ST_ADDR;
  assign rready    = r_state == ST_DATA;
  assign row_valid = r_state == ST_OUT;
  assign busy      = r_state != ST_IDLE;
  assign araddr    = {w_byte[BW_ADDR-1:BW_SZ], {BW_SZ{1'b0}}};
  assign arlen     = r_alen;
  assign arsize    = 3'(BW_SZ);
  assign arburst   = AXI_BURST_INCR;
  assign row_data  = r_row;
  assign row_last  = r_last;
  assign rd_error  = r_err;
endmodule
